// File: rtl/din_conditioner.sv
// Debounce conditioner for an asynchronous level input.
// Two-flop synchronizer followed by a four-state debounce FSM; the
// accepted level and its edge pulses are all registered outputs.
// Rejected pending changes are tallied in a saturating glitch counter.
module din_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_raw,
  input  logic       enable,
  input  logic       glitch_clr,
  output logic       din_clean,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  // Pending count at which the next matching sample completes a change.
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    LOW_PEND = 2'd1,
    HIGH     = 2'd2,
    HIGH_PEND= 2'd3
  } state_t;

  logic       sync1, sync2;
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       rise_nxt, fall_nxt, glitch;
  logic       sample;

  assign sample = sync2;

  // Synchronizer runs every cycle regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din_raw;
      sync2 <= sync1;
    end
  end

  // Next-state, pending count and edge-pulse decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;
    case (state)
      LOW: begin
        cnt_nxt = 8'd0;
        if (enable && sample) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = LOW_PEND;
            cnt_nxt   = 8'd1;
          end
        end
      end
      LOW_PEND: begin
        if (!enable) begin
          // Qualification dropped: abandon the change silently.
          state_nxt = LOW;
          cnt_nxt   = 8'd0;
        end else if (sample) begin
          if (cnt == LAST) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          state_nxt = LOW;
          cnt_nxt   = 8'd0;
          glitch    = 1'b1;
        end
      end
      HIGH: begin
        cnt_nxt = 8'd0;
        if (enable && !sample) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = LOW;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = HIGH_PEND;
            cnt_nxt   = 8'd1;
          end
        end
      end
      HIGH_PEND: begin
        if (!enable) begin
          state_nxt = HIGH;
          cnt_nxt   = 8'd0;
        end else if (!sample) begin
          if (cnt == LAST) begin
            state_nxt = LOW;
            fall_nxt  = 1'b1;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          state_nxt = HIGH;
          cnt_nxt   = 8'd0;
          glitch    = 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // FSM state plus registered level and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOW;
      cnt       <= 8'd0;
      din_clean <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      din_clean <= (state_nxt == HIGH) || (state_nxt == HIGH_PEND);
      rise      <= rise_nxt;
      fall      <= fall_nxt;
    end
  end

  // Saturating glitch tally; a clear overrides a coincident glitch.
  always_ff @(posedge clk) begin
    if (rst || glitch_clr)
      glitch_cnt <= 8'd0;
    else if (glitch && (glitch_cnt != 8'hFF))
      glitch_cnt <= glitch_cnt + 8'd1;
  end

endmodule

// File: tb/tb_din_conditioner.sv
// Bench for din_conditioner: directed scenarios then random traffic,
// every cycle checked against a run-length reference model.
module tb_din_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, din_raw, enable, glitch_clr;
  logic       din_clean, rise, fall;
  logic [7:0] glitch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: raw delay line, accepted level, length of
  // the current run of enabled samples disagreeing with that level.
  int m_d1, m_d2, m_clean, m_run, m_rise, m_fall, m_gc;

  din_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .din_raw(din_raw), .enable(enable),
    .glitch_clr(glitch_clr), .din_clean(din_clean), .rise(rise),
    .fall(fall), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int r, input int e, input int c, input int rs);
    int smp;
    int glitch;
    if (rs != 0) begin
      m_d1 = 0; m_d2 = 0; m_clean = 0; m_run = 0;
      m_rise = 0; m_fall = 0; m_gc = 0;
      return;
    end
    smp = m_d2; m_d2 = m_d1; m_d1 = r;
    m_rise = 0; m_fall = 0; glitch = 0;
    if (e == 0) m_run = 0;
    else if (smp != m_clean) begin
      m_run++;
      if (m_run == D) begin
        m_clean = smp;
        if (smp == 1) m_rise = 1; else m_fall = 1;
        m_run = 0;
      end
    end else begin
      if (m_run > 0) glitch = 1;
      m_run = 0;
    end
    if (c != 0) m_gc = 0;
    else if (glitch != 0 && m_gc < 255) m_gc++;
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic cyc(input int r, input int e, input int c, input int rs);
    din_raw = 1'(r); enable = 1'(e); glitch_clr = 1'(c); rst = 1'(rs);
    @(posedge clk);
    model(r, e, c, rs);
    #1;
    chk("din_clean", 32'(din_clean), 32'(m_clean));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(m_gc));
    chk("rise_fall_excl", 32'(rise & fall), 32'd0);
  endtask

  initial begin
    int gc0;
    int len;
    int lvl;
    din_raw = 0; enable = 1; glitch_clr = 0; rst = 1;

    // Reset state
    repeat (3) cyc(0, 1, 0, 1);
    chk("rst_clean", 32'(din_clean), 32'd0);
    chk("rst_gc", 32'(glitch_cnt), 32'd0);

    // Held 0->1: level and rise appear on the sixth edge only
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 0, 0);
      chk("lat_clean", 32'(din_clean), 32'(k >= 5));
      chk("lat_rise", 32'(rise), 32'(k == 5));
      chk("lat_fall", 32'(fall), 32'd0);
    end

    // In HIGH, 3-cycle low dip is rejected and counted
    repeat (3) cyc(0, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 0);
    chk("dip_clean", 32'(din_clean), 32'd1);
    chk("dip_gc", 32'(glitch_cnt), 32'd1);
    // Then low held: fall on the sixth edge
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 0);
      chk("fall_clean", 32'(din_clean), 32'(k < 5));
      chk("fall_pulse", 32'(fall), 32'(k == 5));
    end

    // 2-cycle high pulse from LOW is rejected
    repeat (2) cyc(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 0, 0);
      chk("short_rise", 32'(rise), 32'd0);
    end
    chk("short_clean", 32'(din_clean), 32'd0);
    chk("short_gc", 32'(glitch_cnt), 32'd2);

    // Enable drop mid-pending: no glitch, full restart on re-enable
    repeat (4) cyc(1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    chk("en_clean", 32'(din_clean), 32'd0);
    chk("en_gc", 32'(glitch_cnt), 32'd2);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0);
      chk("reen_clean", 32'(din_clean), 32'(k >= 3));
      chk("reen_rise", 32'(rise), 32'(k == 3));
    end

    // Reset while HIGH with input high: drop without fall, rise again later
    cyc(1, 1, 0, 1);
    chk("rsth_clean", 32'(din_clean), 32'd0);
    chk("rsth_fall", 32'(fall), 32'd0);
    chk("rsth_gc", 32'(glitch_cnt), 32'd0);
    for (int k = 0; k < 7; k++) begin
      cyc(1, 1, 0, 0);
      chk("rel_clean", 32'(din_clean), 32'(k >= 5));
      chk("rel_rise", 32'(rise), 32'(k == 5));
    end
    repeat (8) cyc(0, 1, 0, 0);

    // 300 glitches saturate at 255
    for (int g = 0; g < 300; g++) begin
      cyc(1, 1, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
    end
    chk("sat_gc", 32'(glitch_cnt), 32'd255);
    // Clear coincident with a glitch event wins
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("clr_gc", 32'(glitch_cnt), 32'd0);

    // Random traffic: runs of random length, occasional enable/clr/reset
    lvl = 0;
    for (int k = 0; k < 400; k++) begin
      len = int'($urandom_range(1, 7));
      lvl = 1 - lvl;
      for (int j = 0; j < len; j++)
        cyc(lvl, int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 29) == 0),
            int'($urandom_range(0, 199) == 0));
    end
    gc0 = m_gc;
    chk("rand_gc_final", 32'(glitch_cnt), 32'(gc0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/din_conditioner.md
DIN_CONDITIONER -- requirements
Module: din_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive matching synchronized samples required to accept a level change (legal 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all sequential logic.
REQ-003 SHALL have port rst  input  1  reset: rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port din_raw  input  1  asynchronous, possibly bouncing serial/button level.
REQ-005 SHALL have port enable  input  1  qualification enable for the debounce state machine.
REQ-006 SHALL have port glitch_clr  input  1  single-cycle clear of glitch_cnt.
REQ-007 SHALL have port din_clean  output  1  debounced level, registered; this is the din feed for the downstream Moore sequence FSM.
REQ-008 SHALL have port rise  output  1  one-cycle pulse coincident with a din_clean 0->1 change.
REQ-009 SHALL have port fall  output  1  one-cycle pulse coincident with a din_clean 1->0 change.
REQ-010 SHALL have port glitch_cnt  output  8  saturating count of rejected pending changes.

Function
REQ-011 SHALL pass din_raw through a 2-flop synchronizer (sync1, sync2); "sample" means sync2; the synchronizer runs regardless of enable.
REQ-012 SHALL implement states LOW, LOW_PEND, HIGH, HIGH_PEND with an 8-bit pending counter cnt.
REQ-013 SHALL drive din_clean = 0 in LOW/LOW_PEND and 1 in HIGH/HIGH_PEND, all outputs registered.
REQ-014 LOW, sample=1, DEBOUNCE_CYCLES>1: next LOW_PEND, cnt=1; DEBOUNCE_CYCLES=1: next HIGH directly with rise.
REQ-015 LOW_PEND, sample=1: if cnt==DEBOUNCE_CYCLES-1 next HIGH, rise=1, cnt=0; else cnt+1.
REQ-016 LOW_PEND, sample=0: next LOW, cnt=0, glitch_cnt+1.
REQ-017 HIGH/HIGH_PEND SHALL mirror REQ-014..016 with sample polarity inverted and fall in place of rise.
REQ-018 Latency: a din_raw change held stable SHALL update din_clean on exactly the (2+DEBOUNCE_CYCLES)-th rising edge after the first edge sampling the new level.
REQ-019 A din_raw pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL never change din_clean.
REQ-020 rise and fall SHALL each be high for exactly one cycle per accepted change and never simultaneously.
REQ-021 enable=0: LOW/HIGH hold; LOW_PEND->LOW, HIGH_PEND->HIGH, cnt=0, no glitch count, no pulses.
REQ-022 glitch_cnt SHALL saturate at 255 (no wrap).
REQ-023 glitch_clr=1 SHALL set glitch_cnt=0 next edge; clr and a simultaneous glitch event -> result 0 (clr wins).
REQ-024 SHALL be free of latches; next-state logic fully assigned in every state, illegal state encodings recover to LOW.

Reset
REQ-025 rst=1 at a clock edge SHALL set sync1=sync2=0, state=LOW, cnt=0, din_clean=0, rise=0, fall=0, glitch_cnt=0.
REQ-026 Reset asserted mid-pending or mid-HIGH SHALL produce no rise/fall pulse and no glitch count; din_clean drops to 0 after the reset edge without a fall pulse.
REQ-027 After rst deasserts with din_raw=1, HIGH SHALL be reached per REQ-018 timing with a rise pulse.

Verification
REQ-028 DEBOUNCE_CYCLES=4, din_raw 0->1 sampled at edge E, held -> din_clean=1 and rise=1 after edge E+5 for one cycle only; fall never asserts.
REQ-029 din_raw high for 2 cycles then low -> din_clean stays 0, glitch_cnt=1, no rise.
REQ-030 In HIGH, din_raw low 3 cycles then high -> din_clean stays 1, glitch_cnt increments by 1; then low held -> fall pulse at E+5.
REQ-031 300 injected glitches -> glitch_cnt=255; glitch_clr coincident with a glitch -> glitch_cnt=0.
REQ-032 enable=0 during LOW_PEND (cnt=2) -> returns to LOW, glitch_cnt unchanged; re-enable with din_raw held high -> full DEBOUNCE_CYCLES restart.
REQ-033 rst pulsed while HIGH with din_raw=1 -> din_clean=0 at reset edge, no fall; rise reasserts per REQ-018 after release.
